mem_access_unit: RTL

Data-memory responder for the single-cycle RV64 core. It accepts one load or store command from the decode/execute stage (memory-control code, ALU-computed address, rs2 store data), runs it on the 64-bit data-bus request/response handshake, and returns sign- or zero-extended load data to the register write-back mux. It is the consumer of the control unit's memory-control/enable outputs and stalls the core while an access is outstanding.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_access_unit_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access codes, control
// field layout, FSM states and bus lane geometry.
package mem_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned BUS_W = 8 * LANES;

  localparam logic [3:0] MEM_LB  = 4'b0000;
  localparam logic [3:0] MEM_LH  = 4'b0001;
  localparam logic [3:0] MEM_LW  = 4'b0010;
  localparam logic [3:0] MEM_LD  = 4'b0011;
  localparam logic [3:0] MEM_LBU = 4'b0100;
  localparam logic [3:0] MEM_LHU = 4'b0101;
  localparam logic [3:0] MEM_LWU = 4'b0110;
  localparam logic [3:0] MEM_SB  = 4'b1000;
  localparam logic [3:0] MEM_SH  = 4'b1001;
  localparam logic [3:0] MEM_SW  = 4'b1010;
  localparam logic [3:0] MEM_SD  = 4'b1011;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR
  } state_t;

  function automatic logic code_valid(input logic [3:0] code);
    case (code)
      MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU,
      MEM_SB, MEM_SH, MEM_SW, MEM_SD: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: access checking, store lane placement/strobes and
// load extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_ctrl_t        ctrl,
  input  logic [2:0]       offset,
  input  logic [BUS_W-1:0] wdata,
  input  logic [BUS_W-1:0] rword,
  output logic             bad,
  output logic [BUS_W-1:0] lane_wdata,
  output logic [LANES-1:0] lane_wstrb,
  output logic [BUS_W-1:0] load_data
);

  logic [LANES-1:0] size_mask;
  logic [2:0]       align_mask;
  logic [BUS_W-1:0] shifted;
  logic             sgn;

  always_comb begin
    size_mask  = 8'h01;
    align_mask = 3'b000;
    case (ctrl.funct3[1:0])
      2'd0: begin size_mask = 8'h01; align_mask = 3'b000; end
      2'd1: begin size_mask = 8'h03; align_mask = 3'b001; end
      2'd2: begin size_mask = 8'h0F; align_mask = 3'b011; end
      default: begin size_mask = 8'hFF; align_mask = 3'b111; end
    endcase

    bad        = !code_valid(ctrl) || (|(offset & align_mask));
    lane_wstrb = size_mask << offset;
    lane_wdata = wdata << {offset, 3'b000};
    shifted    = rword >> {offset, 3'b000};

    sgn       = 1'b0;
    load_data = '0;
    case (ctrl.funct3[1:0])
      2'd0: begin
        sgn       = ~ctrl.funct3[2] & shifted[7];
        load_data = {{56{sgn}}, shifted[7:0]};
      end
      2'd1: begin
        sgn       = ~ctrl.funct3[2] & shifted[15];
        load_data = {{48{sgn}}, shifted[15:0]};
      end
      2'd2: begin
        sgn       = ~ctrl.funct3[2] & shifted[31];
        load_data = {{32{sgn}}, shifted[31:0]};
      end
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory responder: accepts one load/store, runs it on the 64-bit bus
// handshake and returns extended load data while stalling the core.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t     state, state_nxt;
  mem_ctrl_t  ctrl_in, ctrl_q, ctrl_sel;
  logic [2:0] offset_q, offset_sel;
  logic       accept;
  logic       bad;
  logic [DATA_W-1:0] lane_wdata, load_data;
  logic [7:0]        lane_wstrb;

  assign ctrl_in = mem_ctrl;

  // One aligner serves both phases: live request fields while idle (error
  // check and store lanes), latched fields afterwards (load extraction).
  assign ctrl_sel   = (state == IDLE) ? ctrl_in : ctrl_q;
  assign offset_sel = (state == IDLE) ? addr[2:0] : offset_q;

  mem_lane_align u_align (
    .ctrl       (ctrl_sel),
    .offset     (offset_sel),
    .wdata      (wdata),
    .rword      (bus_rdata),
    .bad        (bad),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad ? ERR : REQ;
      end
      REQ:  if (bus_req_ready) state_nxt = WAIT;
      WAIT: if (bus_resp_valid) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;
  assign stall  = accept | (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      offset_q      <= '0;
      rdata         <= '0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
    end else begin
      if (accept) begin
        ctrl_q   <= ctrl_in;
        offset_q <= addr[2:0];
        rdata    <= '0;
        if (!bad) begin
          bus_req_valid <= 1'b1;
          bus_we        <= ctrl_in.store;
          bus_addr      <= {addr[ADDR_W-1:3], 3'b000};
          bus_wdata     <= ctrl_in.store ? lane_wdata : '0;
          bus_wstrb     <= ctrl_in.store ? lane_wstrb : '0;
        end
      end else if (bus_req_valid && bus_req_ready) begin
        bus_req_valid <= 1'b0;
      end
      if (state == WAIT && bus_resp_valid) rdata <= ctrl_q.store ? '0 : load_data;
    end
  end

endmodule
